// File: rtl/stp16_pkg.sv
// Shared definitions for the STP16 shift-register link (transmitter and receiver).
package stp16_pkg;

    localparam int STP16_DEFAULT_WIDTH = 32;
    localparam int STP16_SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        STREAM_HOLD,
        STREAM_LOAD,
        STREAM_OVERWRITE,
        STREAM_ACCEPT
    } stream_op_e;

    // The bit counter must hold 0..WIDTH+1 (it saturates one past a full frame).
    function automatic int stp16_count_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/stp16_sync_edge.sv
// Multi-flop input synchronizer with programmable reset value and an optional
// registered rising-edge detector.
module stp16_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0,
    parameter bit   EDGE_EN   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
        end
    end

    assign o_level = r_sync[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic r_prev;
            logic r_rise;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_prev <= RESET_VAL;
                    r_rise <= 1'b0;
                end else begin
                    r_prev <= o_level;
                    r_rise <= o_level & ~r_prev;
                end
            end

            assign o_rise = r_rise;
        end else begin : g_level
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/stp16_serial_receiver.sv
// Receiver that rebuilds the STP16CPC26 shift/latch behaviour from its pins and
// streams each latched word. Optional length check: STP16_RX_FRAME_CHECK_EN.
module stp16_serial_receiver
    import stp16_pkg::*;
#(
    parameter int WIDTH       = STP16_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = STP16_SYNC_STAGES
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             stp16_clk,
    input  logic             stp16_sdi,
    input  logic             stp16_le,
    input  logic             stp16_noe,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_latched,
    output logic [WIDTH-1:0] o_display,
    output logic             o_enable,
    output logic             o_overrun,
    output logic             o_frame_error,
    input  logic             i_clear
);

    localparam int             CW         = stp16_count_width(WIDTH);
    localparam logic [CW-1:0]  FULL_COUNT = CW'(WIDTH);
    localparam logic [CW-1:0]  SAT_COUNT  = CW'(WIDTH + 1);

    logic             w_clk_rise;
    logic             w_le_rise;
    logic             w_sdi;
    logic             w_noe;
    logic             w_clk_level;
    logic             w_le_level;
    logic             w_sdi_rise;
    logic             w_noe_rise;
    logic             w_unused_sync;

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_latched;
    logic [WIDTH-1:0] r_display;
    logic             r_enable;
    logic             r_overrun;
    logic             r_frame_error;

    logic [WIDTH-1:0] w_shift_next;
    logic [CW-1:0]    w_count_inc;
    logic [CW-1:0]    w_post_count;
    logic             w_frame_bad;
    logic             w_push;
    stream_op_e       w_stream_op;

    stp16_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_clk (
        .clk     (clk),
        .reset   (reset),
        .i_pin   (stp16_clk),
        .o_level (w_clk_level),
        .o_rise  (w_clk_rise)
    );

    stp16_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_le (
        .clk     (clk),
        .reset   (reset),
        .i_pin   (stp16_le),
        .o_level (w_le_level),
        .o_rise  (w_le_rise)
    );

    stp16_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_sdi (
        .clk     (clk),
        .reset   (reset),
        .i_pin   (stp16_sdi),
        .o_level (w_sdi),
        .o_rise  (w_sdi_rise)
    );

    // Output enable resets to "disabled" so the display stays dark until driven.
    stp16_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_noe (
        .clk     (clk),
        .reset   (reset),
        .i_pin   (stp16_noe),
        .o_level (w_noe),
        .o_rise  (w_noe_rise)
    );

    assign w_unused_sync = w_clk_level ^ w_le_level ^ w_sdi_rise ^ w_noe_rise;

    always_comb begin
        w_shift_next = r_shift;
        if (w_clk_rise) begin
            w_shift_next = {r_shift[WIDTH-2:0], w_sdi};
        end
    end

    assign w_count_inc  = (r_count == SAT_COUNT) ? r_count : r_count + 1'b1;
    assign w_post_count = w_clk_rise ? w_count_inc : r_count;

`ifdef STP16_RX_FRAME_CHECK_EN
    assign w_frame_bad = (w_post_count != FULL_COUNT);
`else
    assign w_frame_bad = 1'b0;
`endif

    assign w_push = w_le_rise & ~w_frame_bad;

    // A push while the consumer is also accepting is a plain reload, not an overrun.
    always_comb begin
        w_stream_op = STREAM_HOLD;
        if (w_push) begin
            w_stream_op = (r_valid && !o_ready) ? STREAM_OVERWRITE : STREAM_LOAD;
        end else if (r_valid && o_ready) begin
            w_stream_op = STREAM_ACCEPT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift       <= '0;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_latched     <= '0;
            r_display     <= '0;
            r_enable      <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_shift <= w_shift_next;

            if (w_le_rise) begin
                r_count   <= '0;
                r_latched <= w_shift_next;
            end else begin
                r_count <= w_post_count;
            end

            case (w_stream_op)
                STREAM_LOAD, STREAM_OVERWRITE: begin
                    r_data  <= w_shift_next;
                    r_valid <= 1'b1;
                end
                STREAM_ACCEPT: r_valid <= 1'b0;
                default: ;
            endcase

            r_overrun     <= (r_overrun & ~i_clear) | (w_stream_op == STREAM_OVERWRITE);
            r_frame_error <= (r_frame_error & ~i_clear) | (w_le_rise & w_frame_bad);

            r_enable  <= ~w_noe;
            r_display <= r_latched & {WIDTH{~w_noe}};
        end
    end

    assign o_valid       = r_valid;
    assign o_data        = r_data;
    assign o_latched     = r_latched;
    assign o_display     = r_display;
    assign o_enable      = r_enable;
    assign o_overrun     = r_overrun;
    assign o_frame_error = r_frame_error;

endmodule

// File: doc/stp16_serial_receiver.md
Name: stp16_serial_receiver

Overview:
Receive-side counterpart of the STP16CPC26 LED shift-register driver. The block samples the four driver pins (stp16_clk, stp16_sdi, stp16_le, stp16_noe), which are asynchronous to its own clock. It rebuilds the shift/latch behaviour of the real device and presents each latched word on a valid/ready stream. It is used for loopback self-test of the level-meter LED chain and as an on-chip display emulator.

Parameters:
WIDTH, 32, bits per frame; width of the shift and latch registers; must be >= 2.
SYNC_STAGES, 2, flip-flop depth of each input synchronizer; must be >= 2.

Ports:
reset  in  1  Asynchronous reset, active-high.
clk  in  1  Block clock; at least 4x the stp16_clk toggle rate.
stp16_clk  in  1  Serial shift clock; asynchronous.
stp16_sdi  in  1  Serial data, MSB first; asynchronous.
stp16_le  in  1  Latch enable; asynchronous.
stp16_noe  in  1  Output enable, active-low; asynchronous.
o_valid  out  1  Stream word available.
o_ready  in  1  Consumer accepts the word.
o_data  out  WIDTH  Latched frame.
o_latched  out  WIDTH  Mirror of the device latch register.
o_display  out  WIDTH  o_latched gated by the output enable.
o_enable  out  1  Synchronized, inverted stp16_noe.
o_overrun  out  1  Sticky: a word was overwritten before it was accepted.
o_frame_error  out  1  Sticky: latch pulse with bit count != WIDTH (feature only).
i_clear  in  1  Synchronous clear of the sticky flags.

Behaviour:
- Reset values: o_valid=0, o_data=0, o_latched=0, o_display=0, o_enable=0, o_overrun=0, o_frame_error=0. Shift register = 0. Bit count = 0. All synchronizer flops = 0, except the stp16_noe synchronizer, which resets to 1 so the output stays disabled.
- Every pin passes through a SYNC_STAGES synchronizer. Rising edges of synced clk and synced le are detected against a one-cycle-delayed copy (edge detect stage E).
- Commit stage C runs one cycle after E.
  - A clk edge shifts: shift <= {shift[WIDTH-2:0], sdi_sync}. sdi_sync is the value sampled in cycle C, so sdi must be stable for >= 2 clk cycles after the stp16_clk rise.
  - count increments and saturates at WIDTH+1.
- An le edge also commits in stage C.
  - o_latched <= post-shift value. If a shift commits in the same cycle, the latch takes the newly shifted word.
  - count <= 0.
  - The word is pushed to the stream.
- Stream push rules:
  - No word pending: o_data <= word, o_valid <= 1.
  - o_valid=1 and o_ready=0: word overwrites o_data (newest wins), o_overrun <= 1.
  - o_valid=1 and o_ready=1 in the same cycle: new word loaded, o_valid stays 1, no overrun.
  - Acceptance: o_valid && o_ready with no push clears o_valid next cycle.
- Total latency from the le pin rise to o_valid: SYNC_STAGES+2 clk cycles.
- Output enable: o_enable = ~noe_sync, registered. o_display = o_latched & {WIDTH{o_enable}}, registered.
- i_clear clears both sticky flags. If i_clear coincides with a new error, the error wins and the flag stays 1.
- Pins held static: no state change. Reset mid-frame discards the partial shift contents and any pending word.

Optional Feature:
STP16_RX_FRAME_CHECK_EN
- Defined:
  - On an le edge with post-shift count != WIDTH, o_frame_error <= 1.
  - The bad word still updates o_latched, as the device would, but is NOT pushed to the stream.
- Undefined: o_frame_error is tied to 0 and every le edge pushes a word.

Decomposition:
- Shared package stp16_pkg:
  - STP16_DEFAULT_WIDTH = 32 and STP16_SYNC_STAGES = 2, also used by the transmitter.
  - Count width helper: $clog2(WIDTH+2).
- Sub-module stp16_sync_edge: parameterised synchronizer with reset value and rising-edge output. Instantiated for clk and le; used in level-only mode for sdi and noe.

Test Plan:
- Drive 0xA5C3_0F81 MSB-first over 32 clk pulses, then an le pulse -> o_valid=1 within 4 clk, o_data=0xA5C3_0F81, o_latched equal, o_frame_error=0.
- Hold noe=1 after the above -> o_display=0; drop noe=0 -> o_display=0xA5C3_0F81 within 3 clk.
- Send two frames (0x1, then 0xFFFF_FFFF) with o_ready=0 -> o_data=0xFFFF_FFFF, o_overrun=1; pulse i_clear -> o_overrun=0.
- With the feature defined, send 31 bits then le -> o_frame_error=1, o_valid stays 0, o_latched updated. Without the feature -> word pushed, flag stays 0.
- le rising in the same clk as the 32nd clk edge, with an MSB pattern of 0x8000_0001 -> latched word includes the final bit: 0x8000_0001.
- Assert reset after 16 bits, then send a full frame 0x0000_00FF -> o_data=0x0000_00FF, no residue from the aborted frame.
